// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a start/busy handshake.
// A watchdog drops the in-flight byte if the transmitter never acknowledges tx_start.
module uart_tx_fifo #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     tx_busy,
    output logic [7:0]               txdata,
    output logic                     tx_start,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     timeout_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [AW:0]   FullCount = DEPTH[AW:0];
    localparam logic [CW-1:0] AckLimit  = ACK_TIMEOUT[CW-1:0];

    typedef enum logic [1:0] {StIdle, StStart, StWaitAck, StWaitDone} state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic [CW-1:0]   to_cnt_q, to_cnt_d;
    logic [7:0]      txdata_q;
    logic            overflow_q, timeout_err_q;
    logic            wr_acc, pop, to_hit;

    assign full        = (count_q == FullCount);
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign txdata      = txdata_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_err_q;

    // Full is registered, so a pop on the same edge never frees room for this write.
    assign wr_acc = wr_en & ~full;

    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        pop      = 1'b0;
        to_hit   = 1'b0;
        tx_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                tx_start = 1'b1;
                to_cnt_d = '0;
                state_d  = StWaitAck;
            end
            StWaitAck: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (to_cnt_d == AckLimit) begin
                        to_hit  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({wr_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            to_cnt_q      <= '0;
            txdata_q      <= 8'h00;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            to_cnt_q <= to_cnt_d;
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                txdata_q <= mem[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end
            if (to_hit) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a queue plus timeline model of the
// FIFO and handshake; the bench also plays the transmitter driving tx_busy.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH       = 16;
    localparam int unsigned ACK_TIMEOUT = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   wr_en;
    logic [7:0]             wr_data;
    logic                   tx_busy;
    logic [7:0]             txdata;
    logic                   tx_start;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic                   timeout_err;

    uart_tx_fifo #(
        .DEPTH      (DEPTH),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .tx_busy    (tx_busy),
        .txdata     (txdata),
        .tx_start   (tx_start),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int t        = 0;

    // Model: queued bytes, sticky flags, and the cycle from which the sender is free.
    logic [7:0] q[$];
    logic [7:0] m_txdata;
    logic       m_ovf, m_terr;
    int         idle_from, start_at, busy_on, busy_off, terr_at;

    // Transmitter knobs: forced ack delay / busy length (-1 = random),
    // fto: 1 never ack, 0 always ack, -1 occasionally never ack.
    int fd  = -1;
    int fl  = -1;
    int fto = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset(input int t_next);
        q.delete();
        m_txdata  = 8'h00;
        m_ovf     = 1'b0;
        m_terr    = 1'b0;
        idle_from = t_next;
        start_at  = -1;
        busy_on   = -1;
        busy_off  = -1;
        terr_at   = -1;
    endtask

    // One clock cycle: check outputs of cycle t, drive inputs, advance the model.
    task automatic step(input bit w, input logic [7:0] wd, input bit r);
        bit pop, acc;
        int d, l;
        check_eq("count", 32'(count), 32'(q.size()));
        check_eq("full", 32'(full), 32'(q.size() == DEPTH));
        check_eq("empty", 32'(empty), 32'(q.size() == 0));
        check_eq("tx_start", 32'(tx_start), 32'(t == start_at));
        check_eq("txdata", 32'(txdata), 32'(m_txdata));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("timeout_err", 32'(timeout_err), 32'(m_terr));

        rst     = r;
        wr_en   = w;
        wr_data = wd;
        tx_busy = (t >= busy_on) && (t < busy_off);

        if (r) begin
            model_reset(t + 1);
        end else begin
            pop = (t >= idle_from) && (q.size() > 0);
            acc = w && (q.size() < DEPTH);
            if (w && !acc) m_ovf = 1'b1;
            if (t + 1 == terr_at) m_terr = 1'b1;
            if (pop) begin
                m_txdata = q.pop_front();
                start_at = t + 1;
                if (fto == 1 || (fto < 0 && $urandom_range(0, 7) == 0)) begin
                    terr_at   = t + 2 + int'(ACK_TIMEOUT);
                    idle_from = terr_at;
                    busy_on   = -1;
                    busy_off  = -1;
                end else begin
                    d = (fd >= 0) ? fd : int'($urandom_range(0, ACK_TIMEOUT - 1));
                    l = (fl > 0) ? fl : int'($urandom_range(1, 6));
                    busy_on   = t + 2 + d;
                    busy_off  = busy_on + l;
                    idle_from = busy_off + 1;
                end
            end
            if (acc) q.push_back(wd);
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    int pct;

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        tx_busy = 1'b0;
        @(posedge clk);
        #1;
        t = 0;
        model_reset(0);
        step(0, 8'h00, 1);

        // Single byte: ack after one cycle, busy for seven.
        fd = 1; fl = 7; fto = 0;
        step(1, 8'hA5, 0);
        repeat (14) step(0, 8'h00, 0);

        // Transmitter never acknowledges, then a normal byte follows.
        fto = 1;
        step(1, 8'h3C, 0);
        repeat (20) step(0, 8'h00, 0);
        fto = 0; fd = -1; fl = -1;
        step(1, 8'h3D, 0);
        repeat (30) step(0, 8'h00, 0);

        // Fill behind a long frame, keep writing through the pop edge.
        step(0, 8'h00, 1);
        fd = 0; fl = 60;
        step(1, 8'h00, 0);
        fl = 2;
        repeat (70) step(1, 8'($urandom), 0);
        fd = -1; fl = -1;
        repeat (400) step(0, 8'h00, 0);

        // Reset while a frame is in flight with bytes queued.
        step(0, 8'h00, 1);
        fd = 0; fl = 20;
        repeat (3) step(1, 8'($urandom), 0);
        repeat (6) step(0, 8'h00, 0);
        step(0, 8'h00, 1);
        repeat (10) step(0, 8'h00, 0);
        fd = -1; fl = -1;

        // Streamed ascending bytes to exercise pointer wrap.
        for (int i = 0; i < 24; i++) begin
            step(1, 8'(i), 0);
            repeat (4) step(0, 8'h00, 0);
        end
        repeat (200) step(0, 8'h00, 0);

        // Random traffic with varying write density and occasional lost acks.
        fto = -1;
        for (int seg = 0; seg < 6; seg++) begin
            pct = (seg % 3 == 0) ? 5 : ((seg % 3 == 1) ? 25 : 70);
            repeat (500) step($urandom_range(0, 99) < pct, 8'($urandom), 0);
            if (seg == 2) step(0, 8'h00, 1);
        end
        repeat (400) step(0, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
